// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one single-port DRAM among four cores; one transaction at a time.
// Latency 3+RD_LAT cycles from request seen in IDLE to ack; cores hold their request until acked.
module dram_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [3:0]            i_req,
   input  logic [3:0]            i_we,
   input  logic [4*ADDR_W-1:0]   i_addr,
   input  logic [4*DATA_W-1:0]   i_wdata,
   output logic [4*DATA_W-1:0]   o_rdata,
   output logic [3:0]            o_ack,
   output logic [3:0]            o_grant,
   output logic [ADDR_W-1:0]     o_mem_addr,
   output logic [DATA_W-1:0]     o_mem_data,
   output logic                  o_mem_rden,
   output logic                  o_mem_wren,
   input  logic [DATA_W-1:0]     i_mem_q
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_ACK   = 2'd3;

   localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

   logic [1:0] state;
   logic [1:0] last_grant;
   logic [1:0] gidx;
   logic       we_l;
   logic [1:0] wait_cnt;

   logic       pick_vld;
   logic [1:0] pick_idx;
   logic [1:0] cand;

   // Scan offsets high to low so the requester closest after last_grant wins.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = 2'd0;
      cand     = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         cand = last_grant + 2'(i + 1);
         if (i_req[cand]) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= S_IDLE;
         last_grant <= 2'd3;
         gidx       <= 2'd0;
         we_l       <= 1'b0;
         wait_cnt   <= 2'd0;
         o_rdata    <= '0;
         o_ack      <= '0;
         o_grant    <= '0;
         o_mem_addr <= '0;
         o_mem_data <= '0;
         o_mem_rden <= 1'b0;
         o_mem_wren <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pick_vld) begin
                  gidx       <= pick_idx;
                  last_grant <= pick_idx;
                  o_grant    <= 4'b0001 << pick_idx;
                  we_l       <= i_we[pick_idx];
                  o_mem_addr <= i_addr[pick_idx*ADDR_W +: ADDR_W];
                  o_mem_rden <= !i_we[pick_idx];
                  o_mem_wren <= i_we[pick_idx];
                  if (i_we[pick_idx]) begin
                     o_mem_data <= i_wdata[pick_idx*DATA_W +: DATA_W];
                  end
                  state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               o_mem_rden <= 1'b0;
               o_mem_wren <= 1'b0;
               wait_cnt   <= 2'd0;
               state      <= S_WAIT;
            end
            S_WAIT: begin
               if (wait_cnt == WAIT_LAST) begin
                  if (!we_l) begin
                     o_rdata[gidx*DATA_W +: DATA_W] <= i_mem_q;
                  end
                  o_ack <= o_grant;
                  state <= S_ACK;
               end else begin
                  wait_cnt <= wait_cnt + 2'd1;
               end
            end
            default: begin
               o_ack   <= '0;
               o_grant <= '0;
               state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: RD_LAT=1 instance for the main flows, RD_LAT=2 instance for latency.
module tb_dram_arbiter;

   logic        i_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req   = '0;
   logic [3:0]  req2  = '0;
   logic [3:0]  we_v  = '0;
   logic [63:0] addr_v  = '0;
   logic [31:0] wdata_v = '0;

   logic [31:0] rdata, rdata2;
   logic [3:0]  ack, ack2, grant, grant2;
   logic [15:0] mem_addr, mem_addr2;
   logic [7:0]  mem_data, mem_data2, mem_q, mem_q2;
   logic        mem_rden, mem_wren, mem_rden2, mem_wren2;

   int errors = 0;
   int checks = 0;

   always #5 i_clk = ~i_clk;

   dram_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LAT(1)) u_dut (
      .i_clk(i_clk), .i_rst_n(rst_n), .i_req(req), .i_we(we_v), .i_addr(addr_v),
      .i_wdata(wdata_v), .o_rdata(rdata), .o_ack(ack), .o_grant(grant),
      .o_mem_addr(mem_addr), .o_mem_data(mem_data), .o_mem_rden(mem_rden),
      .o_mem_wren(mem_wren), .i_mem_q(mem_q)
   );

   dram_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LAT(2)) u_dut2 (
      .i_clk(i_clk), .i_rst_n(rst_n), .i_req(req2), .i_we(we_v), .i_addr(addr_v),
      .i_wdata(wdata_v), .o_rdata(rdata2), .o_ack(ack2), .o_grant(grant2),
      .o_mem_addr(mem_addr2), .o_mem_data(mem_data2), .o_mem_rden(mem_rden2),
      .o_mem_wren(mem_wren2), .i_mem_q(mem_q2)
   );

   // DRAM models: address registered on the clock, q combinational from the registered address.
   logic [7:0]  mem  [0:65535];
   logic [7:0]  mem2 [0:65535];
   logic [15:0] ap, ap2a, ap2b;

   always @(posedge i_clk) begin
      if (mem_wren) mem[mem_addr] = mem_data;
      if (mem_wren2) mem2[mem_addr2] = mem_data2;
      ap   <= mem_addr;
      ap2a <= mem_addr2;
      ap2b <= ap2a;
   end
   assign mem_q  = mem[ap];
   assign mem_q2 = mem2[ap2b];

   int          rd_pulses = 0, wr_pulses = 0, both_hi = 0;
   logic [15:0] rd_addr_seen = '0, wr_addr_seen = '0;
   logic [7:0]  wr_data_seen = '0;

   always @(negedge i_clk) begin
      if (mem_rden) begin
         rd_pulses++;
         rd_addr_seen = mem_addr;
      end
      if (mem_wren) begin
         wr_pulses++;
         wr_addr_seen = mem_addr;
         wr_data_seen = mem_data;
      end
      if (mem_rden && mem_wren) both_hi++;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic set_core(input int k, input bit we, input logic [15:0] a, input logic [7:0] d);
      we_v[k] = we;
      addr_v[k*16 +: 16] = a;
      wdata_v[k*8 +: 8]  = d;
   endtask

   // Returns the cycle count including the IDLE cycle in which the request is first seen, -1 on timeout.
   task automatic do_txn(input bit sel2, input int k, input bit we, input logic [15:0] a,
                         input logic [7:0] d, output int cyc);
      int  n;
      bit  got;
      set_core(k, we, a, d);
      if (sel2) req2[k] = 1'b1; else req[k] = 1'b1;
      n = 0;
      got = 1'b0;
      while (!got && n < 20) begin
         tick();
         n++;
         got = sel2 ? ack2[k] : ack[k];
      end
      if (sel2) req2[k] = 1'b0; else req[k] = 1'b0;
      cyc = got ? n + 1 : -1;
   endtask

   int ord [8];
   int gap_bad;

   task automatic run_multi(input logic [3:0] mask, input int nacks, input bit hold);
      int n, cnt, last;
      for (int i = 0; i < 8; i++) ord[i] = -1;
      gap_bad = 0;
      cnt = 0;
      last = 0;
      n = 0;
      req = mask;
      while (cnt < nacks && n < 80) begin
         tick();
         n++;
         for (int k = 0; k < 4; k++) begin
            if (ack[k]) begin
               ord[cnt] = k;
               if (cnt > 0 && n - last != 4) gap_bad++;
               last = n;
               cnt++;
               if (!hold) req[k] = 1'b0;
            end
         end
      end
      req = '0;
      tick();
   endtask

   int cyc;
   int rp0, wp0;

   initial begin
      mem[16'h0010]  = 8'hA5;
      mem[16'h0020]  = 8'h5A;
      mem[16'h0030]  = 8'hEE;
      for (int k = 0; k < 4; k++) mem[16'h0100 + 16'(k)] = 8'h10 + 8'(k);
      mem2[16'h0040] = 8'h77;

      repeat (3) tick();
      chk("rst_ctl", {28'd0, ack | grant, mem_rden, mem_wren}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_mem", {8'd0, mem_addr, mem_data}, 32'd0);
      rst_n = 1'b1;
      tick();

      rp0 = rd_pulses; wp0 = wr_pulses;
      do_txn(1'b0, 2, 1'b0, 16'h0010, 8'h00, cyc);
      chk("rd_lat", cyc, 4);
      chk("rd_grant", {28'd0, grant}, 32'h4);
      chk("rd_pulses", rd_pulses - rp0, 1);
      chk("rd_addr", {16'd0, rd_addr_seen}, 32'h0010);
      chk("rd_nowr", wr_pulses - wp0, 0);
      chk("rd_lanes", rdata, 32'h00A5_0000);
      tick();

      rp0 = rd_pulses; wp0 = wr_pulses;
      do_txn(1'b0, 1, 1'b1, 16'h1234, 8'h3C, cyc);
      chk("wr_lat", cyc, 4);
      chk("wr_pulses", wr_pulses - wp0, 1);
      chk("wr_nord", rd_pulses - rp0, 0);
      chk("wr_addr_data", {8'd0, wr_addr_seen, wr_data_seen}, 32'h0012_343C);
      chk("wr_lanes", rdata, 32'h00A5_0000);
      tick();
      do_txn(1'b0, 1, 1'b0, 16'h1234, 8'h00, cyc);
      chk("rb_lanes", rdata, 32'h00A5_3C00);
      tick();

      // Fresh pointer so the rotation starts at core 0.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) set_core(k, 1'b0, 16'h0100 + 16'(k), 8'h00);
      run_multi(4'b1111, 8, 1'b1);
      for (int i = 0; i < 8; i++) chk($sformatf("rr_order%0d", i), ord[i], i % 4);
      chk("rr_gap", gap_bad, 0);
      chk("rr_lanes", rdata, 32'h1312_1110);

      do_txn(1'b0, 2, 1'b0, 16'h0010, 8'h00, cyc);
      tick();
      set_core(1, 1'b0, 16'h0101, 8'h00);
      set_core(3, 1'b0, 16'h0103, 8'h00);
      run_multi(4'b1010, 2, 1'b0);
      chk("wrap_first", ord[0], 3);
      chk("wrap_second", ord[1], 1);

      set_core(0, 1'b0, 16'h0020, 8'h00);
      req[0] = 1'b1;
      tick();
      tick();
      req[0] = 1'b0;
      addr_v[15:0] = 16'hFFFF;
      tick();
      chk("drop_ack", {31'd0, ack[0]}, 32'd1);
      chk("drop_data", {24'd0, rdata[7:0]}, 32'h5A);
      tick();

      set_core(1, 1'b0, 16'h0030, 8'h00);
      req[1] = 1'b1;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("arst_ctl", {28'd0, ack | grant, mem_rden, mem_wren}, 32'd0);
      chk("arst_rdata", rdata, 32'd0);
      chk("arst_addr", {16'd0, mem_addr}, 32'd0);
      req[1] = 1'b0;
      tick();
      tick();
      chk("arst_noack", {28'd0, ack}, 32'd0);
      rst_n = 1'b1;
      set_core(0, 1'b0, 16'h0100, 8'h00);
      set_core(3, 1'b0, 16'h0103, 8'h00);
      run_multi(4'b1001, 2, 1'b0);
      chk("arst_prio0", ord[0], 0);
      chk("arst_prio1", ord[1], 3);

      do_txn(1'b1, 2, 1'b0, 16'h0040, 8'h00, cyc);
      chk("lat2_cyc", cyc, 5);
      chk("lat2_lanes", rdata2, 32'h0077_0000);
      tick();

      chk("one_enable", both_hi, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Shares one single-port DRAM between the four matrix-multiply cores.
- Each core keeps a private request/acknowledge channel. The arbiter picks one pending request by round-robin and drives it onto the DRAM port.
- It returns read data on that core's lane and pulses that core's acknowledge.
- Sits between the core data-memory ports and the DRAM instance, in the divided core clock domain.

Parameters:
- ADDR_W, 16, DRAM word address width.
- DATA_W, 8, DRAM data width.
- RD_LAT, 1, DRAM clock-to-q read latency in cycles (registered address, unregistered q). Legal values are 1..3.

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req  in  4  per-core request; bit k = core k
- i_we  in  4  per-core write enable; 1 = write, 0 = read; qualified by i_req
- i_addr  in  4*ADDR_W  per-core address; core k = bits [k*ADDR_W +: ADDR_W]
- i_wdata  in  4*DATA_W  per-core write data; same packing as i_addr
- o_rdata  out  4*DATA_W  per-core read data lane
- o_ack  out  4  one-cycle completion pulse per core
- o_grant  out  4  one-hot: core currently owning DRAM
- o_mem_addr  out  ADDR_W  DRAM address
- o_mem_data  out  DATA_W  DRAM write data
- o_mem_rden  out  1  DRAM read enable
- o_mem_wren  out  1  DRAM write enable
- i_mem_q  in  DATA_W  DRAM read data

Behaviour:
Clocking and reset:
- Clock is i_clk; reset is i_rst_n, asynchronous, active-low.
- Reset values: all outputs 0, FSM in IDLE, round-robin pointer last_grant = 3 (so core 0 has first priority).
- Reset asserted mid-transaction aborts it immediately. No ack is issued and DRAM enables drop asynchronously.

Core protocol:
- A core raises i_req[k] with i_we/i_addr/i_wdata stable and holds them until it sees o_ack[k]=1.
- It deasserts i_req[k], or presents a new request, on the following cycle.
- If i_req[k] drops before its ack, the granted transaction still completes and is acked. Request fields are captured at grant, so later changes are ignored.

FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE: if any i_req bit is set, grant the first requester searching from (last_grant+1) mod 4 upward with wrap.
  - Latch grant index, we, addr and wdata.
  - Set o_grant to the one-hot grant and update last_grant.
  - Go to ISSUE. With no requests, stay in IDLE with o_grant=0.
- ISSUE (1 cycle): drive o_mem_addr = latched addr.
  - Read: o_mem_rden=1, o_mem_wren=0.
  - Write: o_mem_wren=1, o_mem_rden=0, o_mem_data = latched wdata.
  - Go to WAIT.
- WAIT: lasts RD_LAT cycles, counted by an internal counter. o_mem_rden/o_mem_wren = 0 and o_mem_addr is held.
  - On the last WAIT cycle, a read captures i_mem_q into the granted core's o_rdata lane.
  - Go to ACK.
- ACK (1 cycle): o_ack[g]=1 and all other ack bits 0. o_grant cleared at exit. Go to IDLE.
  - i_req is not sampled for arbitration during ACK, so the just-acked core's stale request cannot be regranted.

Timing and data rules:
- Latency from req first seen in IDLE to ack is 3+RD_LAT cycles; with RD_LAT=1 that is 4 cycles. A back-to-back transaction starts no earlier than the cycle after ACK.
- Writes follow the identical state sequence and latency. No o_rdata lane changes on a write.
- An o_rdata lane holds its value until the next read completion for that core; other lanes are untouched.
- Outside ISSUE, o_mem_data holds its last value and the enables are 0. At most one enable is high in any cycle.
- Fairness: with all four requesting continuously, grants rotate 0,1,2,3,0,... Each core waits at most 3 other transactions.

Test Plan:
- Reset, then single read: preload DRAM[0x0010]=0xA5; core 2 reads 0x0010 → o_mem_rden high exactly 1 cycle with addr 0x0010; o_ack[2] 4 cycles after req first sampled; o_rdata lane2=0xA5; other lanes 0.
- Write then read back: core 1 writes 0x3C to 0x1234 → one o_mem_wren pulse with data 0x3C; o_rdata lane1 unchanged. Core 1 then reads 0x1234 → lane1=0x3C.
- Contention: all four request reads of distinct addresses in the same cycle → acks in order 0,1,2,3, one every 4 cycles. Next round after core 3 starts at core 0; no core granted twice in a row while others wait.
- Pointer wrap: after core 2 is served, cores 1 and 3 request together → core 3 granted first, then core 1.
- Mid-transaction events: core 0 drops i_req during WAIT → still acked, data captured. Separately, assert i_rst_n=0 during WAIT → all outputs 0 immediately, no ack, and after release core 0 has first priority.
- RD_LAT=2 build: single read → ack 5 cycles after request; data captured correctly.
